// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: shared sample-tick divider, per-channel
// 2-flop synchroniser, stability counter, and auto-repeat FSM with 1-cycle strobes.
module debounce_multi #(
  parameter int NUM_CH       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic              src_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pb_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] rel_o,
  output logic [NUM_CH-1:0] rpt_o
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int STB_W   = $clog2(STABLE_TICKS + 1);
  localparam int RPT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic             PIN_IDLE  = (ACTIVE_LOW != 0);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_TICKS - 1);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_TICKS - 1);
  localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } rpt_state_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sync1_q, sync2_q, s;
    logic [STB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rpt_q, rpt_d;
    rpt_state_e       st_q, st_d;
    logic [RPT_W-1:0] hcnt_q, hcnt_d;

    // Normalised sample: 1 means pressed regardless of pin polarity.
    assign s = sync2_q ^ PIN_IDLE;

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (tick) begin
        if (s == level_q) begin
          cnt_d = '0;
        end else if (cnt_q == STB_LAST) begin
          level_d = s;
          cnt_d   = '0;
          press_d = s;
          rel_d   = ~s;
        end else begin
          cnt_d = cnt_q + STB_W'(1);
        end
      end
    end

    // Releasing (level_d low) wins over any pending repeat on the same tick.
    always_comb begin
      st_d   = st_q;
      hcnt_d = hcnt_q;
      rpt_d  = 1'b0;
      if ((REPEAT_EN == 0) || !level_d) begin
        st_d   = ST_IDLE;
        hcnt_d = '0;
      end else if (tick) begin
        case (st_q)
          ST_IDLE: begin
            if (press_d) begin
              st_d   = ST_HOLD;
              hcnt_d = '0;
            end
          end
          ST_HOLD: begin
            if (hcnt_q == HOLD_LAST) begin
              rpt_d  = 1'b1;
              hcnt_d = '0;
              st_d   = ST_REPEAT;
            end else begin
              hcnt_d = hcnt_q + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (hcnt_q == REP_LAST) begin
              rpt_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + RPT_W'(1);
            end
          end
          default: begin
            st_d   = ST_IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    // Synchroniser resets to the idle pin level so leaving reset never looks like a press.
    always_ff @(posedge src_clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= PIN_IDLE;
        sync2_q <= PIN_IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
        st_q    <= ST_IDLE;
        hcnt_q  <= '0;
      end else begin
        sync1_q <= pb_i[c];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rpt_q   <= rpt_d;
        st_q    <= st_d;
        hcnt_q  <= hcnt_d;
      end
    end

    assign level_o[c] = level_q;
    assign press_o[c] = press_q;
    assign rel_o[c]   = rel_q;
    assign rpt_o[c]   = rpt_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: scenario tasks plus a cycle-level
// reference model built from tick-sample history and held-tick arithmetic.
module tb_debounce_multi;

  localparam int NUM_CH = 4;
  localparam int AL     = 1;
  localparam int TD     = 4;
  localparam int ST     = 3;
  localparam int HOLD   = 5;
  localparam int RPT    = 2;

  logic              src_clk;
  logic              rst_n;
  logic [NUM_CH-1:0] pb_i;
  logic [NUM_CH-1:0] level_o, press_o, rel_o, rpt_o;
  logic [NUM_CH-1:0] level2, press2, rel2, rpt2;

  debounce_multi #(
    .NUM_CH(NUM_CH), .ACTIVE_LOW(AL), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .REPEAT_EN(1), .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut (
    .src_clk(src_clk), .rst_n(rst_n), .pb_i(pb_i),
    .level_o(level_o), .press_o(press_o), .rel_o(rel_o), .rpt_o(rpt_o)
  );

  debounce_multi #(
    .NUM_CH(NUM_CH), .ACTIVE_LOW(AL), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .REPEAT_EN(0), .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut_norpt (
    .src_clk(src_clk), .rst_n(rst_n), .pb_i(pb_i),
    .level_o(level2), .press_o(press2), .rel_o(rel2), .rpt_o(rpt2)
  );

  initial begin
    src_clk = 1'b0;
    forever #5 src_clk = ~src_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge src_clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // A level flips once the last ST tick samples all disagree with it; repeats are
  // derived from the number of ticks the level has stayed high since its press.
  logic [NUM_CH-1:0] m_lvl, e_press, e_rel, e_rpt;
  bit                d0 [NUM_CH];
  bit                d1 [NUM_CH];
  bit                samp [NUM_CH][$];
  int                held [NUM_CH];
  int                div_m;

  always @(posedge src_clk or negedge rst_n) begin
    bit s, tk, flip;
    if (!rst_n) begin
      div_m   = 0;
      m_lvl   = '0;
      e_press = '0;
      e_rel   = '0;
      e_rpt   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        d0[c] = 1'b0;
        d1[c] = 1'b0;
        held[c] = 0;
        samp[c].delete();
      end
    end else begin
      tk      = (div_m == TD - 1);
      div_m   = (div_m + 1) % TD;
      e_press = '0;
      e_rel   = '0;
      e_rpt   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        s     = d1[c];
        d1[c] = d0[c];
        d0[c] = pb_i[c] ^ AL[0];
        if (tk) begin
          samp[c].push_back(s);
          if (samp[c].size() > ST) void'(samp[c].pop_front());
          flip = (samp[c].size() == ST);
          foreach (samp[c][i]) if (samp[c][i] == m_lvl[c]) flip = 1'b0;
          if (flip) begin
            m_lvl[c] = s;
            if (s) e_press[c] = 1'b1;
            else   e_rel[c]   = 1'b1;
            held[c] = 0;
          end else if (m_lvl[c]) begin
            held[c]++;
            if (held[c] == HOLD || (held[c] > HOLD && (held[c] - HOLD) % RPT == 0))
              e_rpt[c] = 1'b1;
          end
        end
      end
    end
  end

  logic [8*NUM_CH-1:0] obs_w, exp_w;
  assign obs_w = {level_o, press_o, rel_o, rpt_o, level2, press2, rel2, rpt2};
  assign exp_w = {m_lvl, e_press, e_rel, e_rpt, m_lvl, e_press, e_rel, NUM_CH'(0)};

  // ---------------- scenarios ----------------
  int press_cyc;

  task automatic test_reset();
    rst_n = 1'b0;
    pb_i  = '1;
    repeat (3) @(negedge src_clk);
    n_tests++;
    if (obs_w !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", obs_w);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL idle_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_clean_press();
    int seen = 0;
    int noisy = 0;
    pb_i[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL press_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (press_o[0]) begin
        seen++;
        press_cyc = cyc;
      end
      if (press_o[3:1] != 0 || rel_o != 0 || level_o[3:1] != 0) noisy++;
    end
    n_tests++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL clean_press_count got=%0d exp=1", seen);
    end
    n_tests++;
    if (level_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_press_level got=%b exp=1", level_o[0]);
    end
    n_tests++;
    if (noisy != 0) begin
      n_fail++;
      $display("FAIL clean_press_quiet got=%0d exp=0", noisy);
    end
  endtask

  task automatic test_hold();
    int nrpt = 0;
    int lat = 0;
    int late_rpt = 0;
    bit got_rel = 0;
    while (cyc < press_cyc + 240) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL hold_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (rpt_o[0]) begin
        n_tests++;
        if (cyc - press_cyc != 20 + 8 * nrpt) begin
          n_fail++;
          $display("FAIL hold_rpt_time got=%0d exp=%0d", cyc - press_cyc, 20 + 8 * nrpt);
        end
        nrpt++;
      end
    end
    n_tests++;
    if (nrpt != 28) begin
      n_fail++;
      $display("FAIL hold_rpt_count got=%0d exp=28", nrpt);
    end
    pb_i[0] = 1'b1;
    while (!got_rel && lat < 25) begin
      @(negedge src_clk);
      lat++;
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL release_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (rel_o[0]) got_rel = 1;
    end
    n_tests++;
    if (!got_rel || lat < 11 || lat > 16) begin
      n_fail++;
      $display("FAIL release_latency got=%0d seen=%0d exp=11..16", lat, got_rel);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge src_clk);
      if (rpt_o[0] || press_o[0] || rel_o[0] || level_o[0]) late_rpt++;
    end
    n_tests++;
    if (late_rpt != 0) begin
      n_fail++;
      $display("FAIL after_release_quiet got=%0d exp=0", late_rpt);
    end
  endtask

  task automatic test_bounce();
    int bad = 0;
    int np = 0;
    int nr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL bounce_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (press_o[1] || rel_o[1] || rpt_o[1]) bad++;
      if (i % 3 == 2) pb_i[1] = ~pb_i[1];
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bounce_quiet got=%0d exp=0", bad);
    end
    pb_i[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL settle_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (press_o[1]) np++;
      if (rel_o[1]) nr++;
    end
    n_tests++;
    if (np != 1 || nr != 0 || level_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_settle press=%0d rel=%0d lvl=%b exp=1,0,1", np, nr, level_o[1]);
    end
    pb_i[1] = 1'b1;
    repeat (20) @(negedge src_clk);
  endtask

  task automatic test_glitch();
    int bad = 0;
    pb_i[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL glitch_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (level_o[2] || press_o[2] || rel_o[2] || rpt_o[2]) bad++;
      if (i == 5) pb_i[2] = 1'b1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL glitch_quiet got=%0d exp=0", bad);
    end
  endtask

  task automatic test_reset_mid();
    bit armed = 0;
    int bad = 0;
    pb_i[0] = 1'b0;
    for (int i = 0; i < 30 && !armed; i++) begin
      @(negedge src_clk);
      if (m_lvl[0] == 1'b0 && samp[0].size() >= 2 &&
          samp[0][samp[0].size()-1] && samp[0][samp[0].size()-2])
        armed = 1;
    end
    n_tests++;
    if (!armed) begin
      n_fail++;
      $display("FAIL reset_mid_arm got=0 exp=1");
    end
    #2 rst_n = 1'b0;
    pb_i = '1;
    #1;
    n_tests++;
    if (obs_w !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%h exp=0", obs_w);
    end
    repeat (3) @(negedge src_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL post_reset_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (press_o != 0 || rel_o != 0 || rpt_o != 0 || level_o != 0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet got=%0d exp=0", bad);
    end
  endtask

  task automatic test_concurrency();
    int c0 = -1;
    int c3 = -1;
    int r1 = 0;
    int r2 = 0;
    pb_i[0] = 1'b0;
    pb_i[3] = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL concur_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if (press_o[0]) c0 = cyc;
      if (press_o[3]) c3 = cyc;
      if (rpt_o[0]) r1++;
      if (rpt2 != 0) r2++;
    end
    n_tests++;
    if (c0 < 0 || c0 != c3) begin
      n_fail++;
      $display("FAIL concur_press_cycle got=%0d,%0d exp=equal", c0, c3);
    end
    n_tests++;
    if (r2 != 0 || r1 == 0) begin
      n_fail++;
      $display("FAIL repeat_disable norpt=%0d rpt=%0d exp=0,>0", r2, r1);
    end
    pb_i = '1;
    for (int i = 0; i < 25; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL concur_rel_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
    end
  endtask

  // Random bursts on all pins, checked cycle by cycle against the model.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge src_clk);
      n_tests++;
      if (obs_w !== exp_w) begin
        n_fail++;
        $display("FAIL random_model t=%0t got=%h exp=%h", $time, obs_w, exp_w);
      end
      if ($urandom_range(0, 9) == 0) pb_i[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
    end
    pb_i = '1;
    repeat (25) @(negedge src_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_hold();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_concurrency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
